// File: rtl/ipv4_tx_encap_if.sv
// Handshake bundles for the IPv4 transmit encapsulator: an 8-bit AXI-Stream
// byte lane and the IP header-field request that opens each packet.

interface axis8_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tlast;
   logic       trdy;

   modport master (output tdata, output tvalid, output tlast, input trdy);
   modport slave  (input tdata, input tvalid, input tlast, output trdy);
endinterface

interface ip_hdr_if;
   logic        tvalid;
   logic        trdy;
   logic [31:0] src_addr;
   logic [31:0] dst_addr;
   logic [7:0]  protocol;
   logic [15:0] payload_len;

   modport master (output tvalid, output src_addr, output dst_addr, output protocol,
                   output payload_len, input trdy);
   modport slave  (input tvalid, input src_addr, input dst_addr, input protocol,
                   input payload_len, output trdy);
endinterface

// File: rtl/ipv4_tx_encap.sv
// Prepends a 20-byte IPv4 header (IHL 5, computed checksum) to a UDP datagram
// stream and forwards the datagram bytes unmodified toward the MAC.

module ipv4_tx_encap #(
   parameter logic [7:0] TTL     = 8'd64,
   parameter logic       DF_FLAG = 1'b1
) (
   input  logic     i_clk,
   input  logic     i_reset_n,
   ip_hdr_if.slave  s_ip_hdr,
   axis8_if.slave   s_axis,
   axis8_if.master  m_axis,
   output logic     o_len_err
);

   localparam logic [15:0] FLAGS = DF_FLAG ? 16'h4000 : 16'h0000;

   typedef enum logic [2:0] {IDLE, SUM, FOLD, HDR, PAYLOAD} state_t;

   state_t      state;
   state_t      next_state;

   logic [31:0] src_q;
   logic [31:0] dst_q;
   logic [7:0]  proto_q;
   logic [15:0] plen_q;
   logic [15:0] total_len_q;
   logic [31:0] sum_q;
   logic [15:0] csum_q;
   logic [15:0] id_cnt;
   logic [15:0] byte_cnt;
   logic [4:0]  idx_q;
   logic        len_err_q;

   logic [15:0] total_len_calc;
   logic [31:0] sum_calc;
   logic [16:0] fold1;
   logic [15:0] fold2;
   logic [7:0]  hdr_byte;

   logic        hdr_trdy;
   logic        in_trdy;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;

   // Header sum uses the checksum field as zero; total length is folded in directly.
   assign total_len_calc = plen_q + 16'd20;
   assign sum_calc = 32'h0000_4500
                   + {16'h0000, total_len_calc}
                   + {16'h0000, id_cnt}
                   + {16'h0000, FLAGS}
                   + {16'h0000, TTL, proto_q}
                   + {16'h0000, src_q[31:16]}
                   + {16'h0000, src_q[15:0]}
                   + {16'h0000, dst_q[31:16]}
                   + {16'h0000, dst_q[15:0]};
   assign fold1 = {1'b0, sum_q[15:0]} + {1'b0, sum_q[31:16]};
   assign fold2 = fold1[15:0] + {15'h0000, fold1[16]};

   always_comb begin
      hdr_byte = 8'h00;
      case (idx_q)
         5'd0:    hdr_byte = 8'h45;
         5'd1:    hdr_byte = 8'h00;
         5'd2:    hdr_byte = total_len_q[15:8];
         5'd3:    hdr_byte = total_len_q[7:0];
         5'd4:    hdr_byte = id_cnt[15:8];
         5'd5:    hdr_byte = id_cnt[7:0];
         5'd6:    hdr_byte = FLAGS[15:8];
         5'd7:    hdr_byte = FLAGS[7:0];
         5'd8:    hdr_byte = TTL;
         5'd9:    hdr_byte = proto_q;
         5'd10:   hdr_byte = csum_q[15:8];
         5'd11:   hdr_byte = csum_q[7:0];
         5'd12:   hdr_byte = src_q[31:24];
         5'd13:   hdr_byte = src_q[23:16];
         5'd14:   hdr_byte = src_q[15:8];
         5'd15:   hdr_byte = src_q[7:0];
         5'd16:   hdr_byte = dst_q[31:24];
         5'd17:   hdr_byte = dst_q[23:16];
         5'd18:   hdr_byte = dst_q[15:8];
         5'd19:   hdr_byte = dst_q[7:0];
         default: hdr_byte = 8'h00;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) state <= IDLE;
      else            state <= next_state;
   end

   // Outputs are forced low while reset is held, even before the state register clears.
   always_comb begin
      next_state = state;
      hdr_trdy   = 1'b0;
      in_trdy    = 1'b0;
      out_valid  = 1'b0;
      out_data   = 8'h00;
      out_last   = 1'b0;
      case (state)
         IDLE: begin
            hdr_trdy = 1'b1;
            if (s_ip_hdr.tvalid) next_state = SUM;
         end
         SUM:  next_state = FOLD;
         FOLD: next_state = HDR;
         HDR: begin
            out_valid = 1'b1;
            out_data  = hdr_byte;
            if (m_axis.trdy && idx_q == 5'd19) next_state = PAYLOAD;
         end
         PAYLOAD: begin
            out_valid = s_axis.tvalid;
            out_data  = s_axis.tdata;
            out_last  = s_axis.tlast;
            in_trdy   = m_axis.trdy;
            if (s_axis.tvalid && m_axis.trdy && s_axis.tlast) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      if (!i_reset_n) begin
         hdr_trdy  = 1'b0;
         in_trdy   = 1'b0;
         out_valid = 1'b0;
         out_data  = 8'h00;
         out_last  = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         src_q       <= 32'h0;
         dst_q       <= 32'h0;
         proto_q     <= 8'h0;
         plen_q      <= 16'h0;
         total_len_q <= 16'h0;
         sum_q       <= 32'h0;
         csum_q      <= 16'h0;
         id_cnt      <= 16'h0;
         byte_cnt    <= 16'h0;
         idx_q       <= 5'd0;
         len_err_q   <= 1'b0;
      end else begin
         len_err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (s_ip_hdr.tvalid) begin
                  src_q   <= s_ip_hdr.src_addr;
                  dst_q   <= s_ip_hdr.dst_addr;
                  proto_q <= s_ip_hdr.protocol;
                  plen_q  <= s_ip_hdr.payload_len;
               end
            end
            SUM: begin
               total_len_q <= total_len_calc;
               sum_q       <= sum_calc;
               idx_q       <= 5'd0;
            end
            FOLD: csum_q <= ~fold2;
            HDR: begin
               byte_cnt <= 16'h0;
               if (m_axis.trdy) idx_q <= idx_q + 5'd1;
            end
            PAYLOAD: begin
               if (s_axis.tvalid && m_axis.trdy) begin
                  byte_cnt <= byte_cnt + 16'd1;
                  if (s_axis.tlast) begin
                     len_err_q <= (byte_cnt + 16'd1) != plen_q;
                     id_cnt    <= id_cnt + 16'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign s_ip_hdr.trdy = hdr_trdy;
   assign s_axis.trdy   = in_trdy;
   assign m_axis.tvalid = out_valid;
   assign m_axis.tdata  = out_data;
   assign m_axis.tlast  = out_last;
   assign o_len_err     = len_err_q && i_reset_n;

endmodule

// File: tb/tb_ipv4_tx_encap.sv
// Scoreboard bench for ipv4_tx_encap: stimulus queues expected bytes, a
// negedge monitor compares every transferred output byte and len_err pulse.

module tb_ipv4_tx_encap;

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      logic [7:0]  proto;
      logic [15:0] plen;
   } hdr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic len_err;

   ip_hdr_if hdr ();
   axis8_if  s_ax ();
   axis8_if  m_ax ();

   ipv4_tx_encap dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .s_ip_hdr  (hdr),
      .s_axis    (s_ax),
      .m_axis    (m_ax),
      .o_len_err (len_err)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         pulses = 0;
   int         exp_pulses = 0;
   bit         rand_bp = 1'b0;
   logic [8:0] exp_q[$];
   bit         err_q[$];

   logic [7:0] ref_hdr[20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00,
                               8'h40, 8'h11, 8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01,
                               8'hC0, 8'hA8, 8'h00, 8'hC7};

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: timed out, got no handshake, expected one", name);
   endtask

   // Reference IPv4 header byte, checksum via end-around-carry folding.
   function automatic logic [7:0] modelByte(input hdr_t h, input logic [15:0] id, input int i);
      logic [15:0]  tl;
      logic [15:0]  w[10];
      logic [31:0]  acc;
      logic [159:0] v;
      tl = h.plen + 16'd20;
      w = '{16'h4500, tl, id, 16'h4000, {8'd64, h.proto}, 16'h0000,
            h.src[31:16], h.src[15:0], h.dst[31:16], h.dst[15:0]};
      acc = 32'h0;
      foreach (w[j]) acc += {16'h0, w[j]};
      while (acc[31:16] != 16'h0) acc = {16'h0, acc[15:0]} + {16'h0, acc[31:16]};
      v = {w[0], w[1], w[2], w[3], w[4], ~acc[15:0], w[6], w[7], w[8], w[9]};
      return v[159 - 8*i -: 8];
   endfunction

   function automatic logic [7:0] payByte(input logic [7:0] seed, input int k);
      return seed + 8'(k * 13);
   endfunction

   task automatic applyStimulus(input hdr_t h, input int nbytes, input logic [15:0] exp_id,
                                input bit use_ref, input bit check_lat, input int abort_at,
                                input bit exp_err, input logic [7:0] seed);
      bit ok;
      for (int i = 0; i < 20; i++)
         exp_q.push_back({1'b0, use_ref ? ref_hdr[i] : modelByte(h, exp_id, i)});
      for (int k = 0; k < nbytes; k++)
         exp_q.push_back({(k == nbytes - 1), payByte(seed, k)});
      if (abort_at < 0) begin
         err_q.push_back(exp_err);
         if (exp_err) exp_pulses++;
      end

      hdr.src_addr    = h.src;
      hdr.dst_addr    = h.dst;
      hdr.protocol    = h.proto;
      hdr.payload_len = h.plen;
      hdr.tvalid      = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         ok = hdr.trdy;
         @(posedge clk);
         #1;
      end
      hdr.tvalid = 1'b0;
      if (!ok) begin
         timeoutFail("hdr_handshake");
         return;
      end

      if (check_lat) begin
         @(negedge clk);
         checkOutput("latency_sum_tvalid", m_ax.tvalid, 1'b0);
         @(negedge clk);
         checkOutput("latency_fold_tvalid", m_ax.tvalid, 1'b0);
         @(negedge clk);
         checkOutput("latency_hdr_tvalid", m_ax.tvalid, 1'b1);
         @(posedge clk);
         #1;
      end

      for (int k = 0; k < nbytes; k++) begin
         if (k == abort_at) return;
         s_ax.tdata  = payByte(seed, k);
         s_ax.tlast  = (k == nbytes - 1);
         s_ax.tvalid = 1'b1;
         ok = 1'b0;
         for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            ok = s_ax.trdy;
            @(posedge clk);
            #1;
         end
         if (!ok) begin
            s_ax.tvalid = 1'b0;
            timeoutFail("payload_handshake");
            return;
         end
      end
      s_ax.tvalid = 1'b0;
      s_ax.tlast  = 1'b0;
   endtask

   task automatic resetDut();
      rst_n       = 1'b0;
      hdr.tvalid  = 1'b0;
      s_ax.tvalid = 1'b0;
      s_ax.tlast  = 1'b0;
      exp_q.delete();
      err_q.delete();
      @(negedge clk);
      checkOutput("rst_hdr_trdy", hdr.trdy, 1'b0);
      checkOutput("rst_m_tvalid", m_ax.tvalid, 1'b0);
      checkOutput("rst_m_tdata", m_ax.tdata, 8'h00);
      checkOutput("rst_s_trdy", s_ax.trdy, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_hdr_trdy", hdr.trdy, 1'b1);
      checkOutput("post_rst_m_tvalid", m_ax.tvalid, 1'b0);
      checkOutput("post_rst_m_tlast", m_ax.tlast, 1'b0);
      checkOutput("post_rst_s_trdy", s_ax.trdy, 1'b0);
      checkOutput("post_rst_len_err", len_err, 1'b0);
      @(posedge clk);
      #1;
   endtask

   // Downstream ready: always high, or a fair coin per cycle when backpressure is enabled.
   initial begin
      m_ax.trdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_ax.trdy = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: scoreboard pop on every output transfer, hold checks under stall.
   initial begin
      logic       stall_prev;
      logic [7:0] prev_data;
      logic       prev_last;
      bit         err_pending;
      bit         err_exp;
      logic [8:0] e;
      stall_prev  = 1'b0;
      prev_data   = 8'h00;
      prev_last   = 1'b0;
      err_pending = 1'b0;
      err_exp     = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_prev  = 1'b0;
            err_pending = 1'b0;
         end else begin
            if (len_err) pulses++;
            if (err_pending) begin
               checkOutput("len_err_pulse", len_err, err_exp);
               err_pending = 1'b0;
            end else if (len_err) begin
               checkOutput("len_err_spurious", len_err, 1'b0);
            end
            if (stall_prev) begin
               checkOutput("hold_tvalid", m_ax.tvalid, 1'b1);
               checkOutput("hold_tdata_tlast", {m_ax.tlast, m_ax.tdata}, {prev_last, prev_data});
            end
            if (m_ax.tvalid && m_ax.trdy) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_byte: got %h, expected no output", m_ax.tdata);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("out_byte", {m_ax.tlast, m_ax.tdata}, e);
               end
               if (m_ax.tlast) begin
                  err_exp = (err_q.size() != 0) ? err_q.pop_front() : 1'b0;
                  err_pending = 1'b1;
               end
            end
            stall_prev = m_ax.tvalid && !m_ax.trdy;
            prev_data  = m_ax.tdata;
            prev_last  = m_ax.tlast;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no completion, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      hdr_t c1, a, b, c, d;
      c1 = '{32'hC0A80001, 32'hC0A800C7, 8'h11, 16'h005F};
      a  = '{32'h0A000001, 32'h0A000002, 8'h11, 16'h0008};
      b  = '{32'hC0A80001, 32'hFFFFFFFF, 8'h11, 16'h0020};
      c  = '{32'h01020304, 32'h05060708, 8'h06, 16'h0009};
      d  = '{32'hC0A80001, 32'hC0A800C7, 8'h11, 16'h0010};

      hdr.tvalid      = 1'b0;
      hdr.src_addr    = 32'h0;
      hdr.dst_addr    = 32'h0;
      hdr.protocol    = 8'h0;
      hdr.payload_len = 16'h0;
      s_ax.tvalid     = 1'b0;
      s_ax.tdata      = 8'h00;
      s_ax.tlast      = 1'b0;
      @(posedge clk);
      #1;
      resetDut();

      $display("[TB] case 1: reference packet, no backpressure");
      applyStimulus(c1, 95, 16'h0000, 1'b1, 1'b1, -1, 1'b0, 8'h30);

      $display("[TB] case 3: reference packet under random backpressure");
      resetDut();
      rand_bp = 1'b1;
      applyStimulus(c1, 95, 16'h0000, 1'b1, 1'b0, -1, 1'b0, 8'h30);
      rand_bp = 1'b0;

      $display("[TB] case 2/4: back-to-back packets and a length mismatch");
      resetDut();
      applyStimulus(a, 8, 16'h0000, 1'b0, 1'b0, -1, 1'b0, 8'h01);
      applyStimulus(b, 32, 16'h0001, 1'b0, 1'b0, -1, 1'b0, 8'h77);
      applyStimulus(c, 9, 16'h0002, 1'b0, 1'b0, -1, 1'b0, 8'hF0);
      applyStimulus(d, 12, 16'h0003, 1'b0, 1'b0, -1, 1'b1, 8'h22);

      $display("[TB] case 5: reset during payload");
      applyStimulus(a, 8, 16'h0004, 1'b0, 1'b0, 5, 1'b0, 8'h55);
      resetDut();
      applyStimulus(a, 8, 16'h0000, 1'b0, 1'b0, -1, 1'b0, 8'h66);

      $display("[TB] case 6: ID counter wrap");
      force dut.id_cnt = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.id_cnt;
      applyStimulus(c, 9, 16'hFFFF, 1'b0, 1'b0, -1, 1'b0, 8'h10);
      applyStimulus(c, 9, 16'h0000, 1'b0, 1'b0, -1, 1'b0, 8'h20);

      for (int n = 0; n < 1000 && exp_q.size() != 0; n++) @(posedge clk);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("queue_drained", exp_q.size(), 0);
      checkOutput("len_err_pulse_count", pulses, exp_pulses);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
